// File: rtl/qupls_alu_issue_sched_if.sv
// Issue-queue <-> ALU scheduler bundle: request vectors in, grant/issue and divider status out.
interface qupls_alu_issue_sched_if #(
  parameter int NREQ = 8
);
  localparam int CW = $clog2(NREQ);

  logic            flush;
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_div;
  logic            alu_stall;
  logic            div_done;
  logic [NREQ-1:0] grant;
  logic            issue_v;
  logic [CW-1:0]   issue_idx;
  logic            issue_div;
  logic            div_busy;
  logic [CW-1:0]   div_owner;
  logic            div_tmo;

  // Issue queue / ALU side
  modport master (
    output flush, req_valid, req_div, alu_stall, div_done,
    input  grant, issue_v, issue_idx, issue_div, div_busy, div_owner, div_tmo
  );

  // Scheduler side
  modport slave (
    input  flush, req_valid, req_div, alu_stall, div_done,
    output grant, issue_v, issue_idx, issue_div, div_busy, div_owner, div_tmo
  );
endinterface

// File: rtl/qupls_alu_issue_sched.sv
// Round-robin issue scheduler for the shared ALU pipe, with ownership tracking
// and a watchdog for the single iterative divider.
//
// state  | meaning
// D_IDLE | divider free; a divide may issue
// D_BUSY | divider owned by div_owner; divides held off, wdog counting
module qupls_alu_issue_sched #(
  parameter int NREQ    = 8,
  parameter int DIV_TMO = 127
) (
  input logic                   clk,
  input logic                   rst,
  qupls_alu_issue_sched_if.slave sif
);
  localparam int CW = $clog2(NREQ);

  typedef enum logic {D_IDLE, D_BUSY} dstate_t;

  dstate_t         dstate, dstate_nxt;
  logic [CW-1:0]   rr_ptr, rr_nxt;
  logic [CW-1:0]   sel;
  logic [NREQ-1:0] elig;
  logic            any_elig;
  logic            issue_ok;
  logic [7:0]      wdog, wdog_nxt;
  logic [CW-1:0]   owner_nxt;
  logic            tmo_nxt;

  // Divider ownership is a decode of the registered state, so it stays glitch-free.
  assign sif.div_busy = (dstate == D_BUSY);

  // Entries that may issue: ready, not a blocked divide, not the one granted last cycle.
  always_comb begin
    elig = sif.req_valid & ~(sif.req_div & {NREQ{sif.div_busy}}) & ~sif.grant;
  end

  // Rotating priority scan starting at rr_ptr; walking downwards lets the nearest hit win.
  always_comb begin
    sel      = '0;
    any_elig = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (elig[rr_ptr + CW'(k)]) begin
        sel      = rr_ptr + CW'(k);
        any_elig = 1'b1;
      end
    end
  end

  // Flush and stall both veto a new issue; the divider FSM is unaffected by stall.
  always_comb begin
    issue_ok = ~sif.flush & ~sif.alu_stall & any_elig;
    rr_nxt   = issue_ok ? sel + CW'(1) : rr_ptr;
  end

  // Divider FSM next-state: flush beats div_done, which beats the watchdog.
  always_comb begin
    dstate_nxt = dstate;
    wdog_nxt   = wdog;
    owner_nxt  = sif.div_owner;
    tmo_nxt    = 1'b0;
    case (dstate)
      D_IDLE: begin
        if (issue_ok && sif.req_div[sel]) begin
          dstate_nxt = D_BUSY;
          wdog_nxt   = 8'd0;
          owner_nxt  = sel;
        end
      end
      D_BUSY: begin
        if (sif.flush || sif.div_done) begin
          dstate_nxt = D_IDLE;
        end else if (wdog == 8'(DIV_TMO)) begin
          dstate_nxt = D_IDLE;
          tmo_nxt    = 1'b1;
        end else begin
          wdog_nxt = wdog + 8'd1;
        end
      end
      default: dstate_nxt = D_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dstate        <= D_IDLE;
      wdog          <= 8'd0;
      rr_ptr        <= '0;
      sif.grant     <= '0;
      sif.issue_v   <= 1'b0;
      sif.issue_idx <= '0;
      sif.issue_div <= 1'b0;
      sif.div_owner <= '0;
      sif.div_tmo   <= 1'b0;
    end else begin
      dstate        <= dstate_nxt;
      wdog          <= wdog_nxt;
      rr_ptr        <= rr_nxt;
      sif.div_owner <= owner_nxt;
      sif.div_tmo   <= tmo_nxt;
      if (issue_ok) begin
        sif.grant     <= NREQ'(1) << sel;
        sif.issue_v   <= 1'b1;
        sif.issue_idx <= sel;
        sif.issue_div <= sif.req_div[sel];
      end else begin
        sif.grant     <= '0;
        sif.issue_v   <= 1'b0;
        sif.issue_div <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_qupls_alu_issue_sched.sv
// Bench for the ALU issue scheduler: a table of single-cycle vectors for the
// round-robin order, then hand-built divider, stall, flush and reset sequences.
module tb_qupls_alu_issue_sched;
  localparam int NREQ = 8;
  localparam int CW   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  qupls_alu_issue_sched_if #(.NREQ(NREQ)) bus ();

  qupls_alu_issue_sched #(.NREQ(NREQ), .DIV_TMO(127)) dut (
    .clk (clk),
    .rst (rst),
    .sif (bus)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [CW-1:0] sb_q[$];

  typedef struct {
    logic [7:0] rv;
    logic [7:0] rd;
    logic       st;
    logic       ev;
    logic [2:0] eidx;
  } vec_t;
  vec_t vt[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] rv, input logic [7:0] rd, input logic st,
                       input logic fl, input logic dd);
    bus.req_valid = rv;
    bus.req_div   = rd;
    bus.alu_stall = st;
    bus.flush     = fl;
    bus.div_done  = dd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle: drive, push the expected grant, clock, pop and compare.
  task automatic step(input logic [7:0] rv, input logic [7:0] rd, input logic st,
                      input logic fl, input logic dd, input logic ev,
                      input logic [2:0] eidx, input string nm);
    logic [CW-1:0] exp_idx;
    drive(rv, rd, st, fl, dd);
    if (ev) sb_q.push_back(eidx);
    tick();
    chk({nm, "_issue_v"}, 32'(bus.issue_v), 32'(ev));
    if (!ev) chk({nm, "_grant0"}, 32'(bus.grant), 32'd0);
    if (bus.issue_v) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s_sb_empty actual=issue idx %0d expected=no issue", nm, bus.issue_idx);
      end else begin
        exp_idx = sb_q.pop_front();
        chk({nm, "_idx"}, 32'(bus.issue_idx), 32'(exp_idx));
        chk({nm, "_grant"}, 32'(bus.grant), 32'(8'(1) << exp_idx));
      end
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_grant"},     32'(bus.grant),     32'd0);
    chk({nm, "_issue_v"},   32'(bus.issue_v),   32'd0);
    chk({nm, "_issue_idx"}, 32'(bus.issue_idx), 32'd0);
    chk({nm, "_issue_div"}, 32'(bus.issue_div), 32'd0);
    chk({nm, "_div_busy"},  32'(bus.div_busy),  32'd0);
    chk({nm, "_div_owner"}, 32'(bus.div_owner), 32'd0);
    chk({nm, "_div_tmo"},   32'(bus.div_tmo),   32'd0);
  endtask

  // Global time limit so the run can never hang.
  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    logic bad;

    // Round-robin walk with each requester dropping in its grant cycle.
    for (int k = 0; k < 9; k++) begin
      vt[k].rv   = (k == 0) ? 8'hFF : ~(8'(1) << (k - 1));
      vt[k].rd   = 8'h00;
      vt[k].st   = 1'b0;
      vt[k].ev   = 1'b1;
      vt[k].eidx = 3'(k % 8);
    end
    vt[9]  = '{rv: 8'h81, rd: 8'h00, st: 1'b0, ev: 1'b1, eidx: 3'd7};
    vt[10] = '{rv: 8'h00, rd: 8'h00, st: 1'b0, ev: 1'b0, eidx: 3'd0};
    vt[11] = '{rv: 8'h24, rd: 8'h00, st: 1'b1, ev: 1'b0, eidx: 3'd0};
    vt[12] = '{rv: 8'h24, rd: 8'h00, st: 1'b0, ev: 1'b1, eidx: 3'd2};
    vt[13] = '{rv: 8'h24, rd: 8'h00, st: 1'b0, ev: 1'b1, eidx: 3'd5};
    vt[14] = '{rv: 8'h05, rd: 8'h00, st: 1'b0, ev: 1'b1, eidx: 3'd0};
    vt[15] = '{rv: 8'h05, rd: 8'h00, st: 1'b0, ev: 1'b1, eidx: 3'd2};

    drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    #1 rst = 1'b0;
    #2;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      step(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, "idle");
      chk("idle_div_busy", 32'(bus.div_busy), 32'd0);
    end

    // Table vectors
    for (int i = 0; i < 16; i++)
      step(vt[i].rv, vt[i].rd, vt[i].st, 1'b0, 1'b0, vt[i].ev, vt[i].eidx, $sformatf("vec%0d", i));

    // Divide at idx1 holds off divide at idx2 until 2 cycles after div_done
    step(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, "div_gap");
    step(8'h06, 8'h06, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, "div1");
    chk("div1_issue_div", 32'(bus.issue_div), 32'd1);
    chk("div1_busy",      32'(bus.div_busy),  32'd1);
    chk("div1_owner",     32'(bus.div_owner), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(8'h04, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, "div_hold");
      chk("div_hold_busy", 32'(bus.div_busy), 32'd1);
    end
    step(8'h04, 8'h04, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, "div_done");
    chk("div_done_busy", 32'(bus.div_busy), 32'd0);
    step(8'h04, 8'h04, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, "div2");
    chk("div2_issue_div", 32'(bus.issue_div), 32'd1);
    chk("div2_busy",      32'(bus.div_busy),  32'd1);
    chk("div2_owner",     32'(bus.div_owner), 32'd2);

    // Flush while busy, with a pending request
    step(8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, "flush");
    chk("flush_busy",      32'(bus.div_busy),  32'd0);
    chk("flush_issue_div", 32'(bus.issue_div), 32'd0);

    // div_done while idle has no effect
    step(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, "dd_idle");
    chk("dd_idle_busy", 32'(bus.div_busy), 32'd0);

    // Watchdog: issue at idx3, no div_done
    step(8'h08, 8'h08, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, "wd_issue");
    chk("wd_issue_busy", 32'(bus.div_busy), 32'd1);
    drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    bad = 1'b0;
    for (int k = 1; k <= 127; k++) begin
      tick();
      if (!bus.div_busy || bus.div_tmo) bad = 1'b1;
    end
    chk("wd_hold", 32'(bad), 32'd0);
    tick();
    chk("wd_tmo_pulse", 32'(bus.div_tmo),  32'd1);
    chk("wd_tmo_busy",  32'(bus.div_busy), 32'd0);
    tick();
    chk("wd_tmo_clear", 32'(bus.div_tmo),  32'd0);

    // Stall suppresses issue; idx4 issues the cycle after stall drops
    for (int i = 0; i < 3; i++)
      step(8'h10, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, "stall");
    step(8'h10, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, "unstall");

    // Asynchronous reset in D_BUSY with issue_v high, then rr_ptr back to 0
    step(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, "pre_rst");
    step(8'h40, 8'h40, 1'b0, 1'b0, 1'b0, 1'b1, 3'd6, "rst_div");
    chk("rst_div_busy", 32'(bus.div_busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk_all_zero("async_rst");
    sb_q.delete();
    drive(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    step(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, "post_rst");

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
